// File: rtl/ram_port_arbiter.sv
// Round-robin share of one RAM port between two requesters; command registered (en at T+1), read data back at T+1+READ_LATENCY.
// Ready is the combinational grant, one access per cycle; responses have no backpressure and return in acceptance order.
module ram_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 18,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_regce,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam int DEPTH = READ_LATENCY + 1;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic              rr_prio;   // requester that wins a tie
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              acc_id;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  tag_t              tags [DEPTH];

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || !rr_prio))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acc_id     = grant1;
  assign acc_we     = grant1 ? req1_we    : req0_we;
  assign acc_addr   = grant1 ? req1_addr  : req0_addr;
  assign acc_wdata  = grant1 ? req1_wdata : req0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_prio  <= 1'b0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      for (int i = 0; i < DEPTH; i++)
        tags[i] <= '0;
    end else begin
      ram_en <= accept;
      ram_we <= accept & acc_we;
      if (accept) begin
        rr_prio  <= ~acc_id;
        ram_addr <= acc_addr;
        ram_din  <= acc_wdata;
      end
      // Entry k describes the access whose RAM command was k cycles ago.
      tags[0] <= '{vld: accept & ~acc_we, id: acc_id};
      for (int i = 1; i < DEPTH; i++)
        tags[i] <= tags[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      busy = busy | tags[i].vld;
  end

  assign rsp0_valid = tags[DEPTH-1].vld & ~tags[DEPTH-1].id;
  assign rsp1_valid = tags[DEPTH-1].vld &  tags[DEPTH-1].id;
  assign rsp0_rdata = ram_dout;
  assign rsp1_rdata = ram_dout;
  assign ram_rst    = rst;

  // The output register must capture only in the cycle after a read command.
  generate
    if (READ_LATENCY == 1) begin : g_low_lat
      assign ram_regce = 1'b1;
    end else begin : g_high_perf
      assign ram_regce = tags[1].vld;
    end
  endgenerate

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: two arbiters (READ_LATENCY 2 and 1) share the same request stimulus, each with its own RAM model.
module tb_ram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int N  = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr  = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr  = '0;
  logic [DW-1:0] req1_wdata = '0;

  logic          a_ready0, a_ready1, a_rsp0_valid, a_rsp1_valid, a_en, a_we, a_regce, a_rrst, a_busy;
  logic [DW-1:0] a_rsp0_rdata, a_rsp1_rdata, a_din, a_dout;
  logic [AW-1:0] a_addr;
  logic          b_ready0, b_ready1, b_rsp0_valid, b_rsp1_valid, b_en, b_we, b_regce, b_rrst, b_busy;
  logic [DW-1:0] b_rsp0_rdata, b_rsp1_rdata, b_din, b_dout;
  logic [AW-1:0] b_addr;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(a_ready0), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(a_ready1), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(a_rsp0_valid), .rsp0_rdata(a_rsp0_rdata), .rsp1_valid(a_rsp1_valid), .rsp1_rdata(a_rsp1_rdata),
    .ram_en(a_en), .ram_we(a_we), .ram_addr(a_addr), .ram_din(a_din), .ram_regce(a_regce),
    .ram_rst(a_rrst), .ram_dout(a_dout), .busy(a_busy));

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut_ll (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(b_ready0), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(b_ready1), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata), .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
    .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr), .ram_din(b_din), .ram_regce(b_regce),
    .ram_rst(b_rrst), .ram_dout(b_dout), .busy(b_busy));

  // Read-first RAM models
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] lat_a;
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    lat_a  = '0;
    a_dout = '0;
    b_dout = '0;
  end
  always @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem_a[a_addr] <= a_din;
      lat_a <= mem_a[a_addr];
    end
    if (a_rrst) a_dout <= '0;
    else if (a_regce) a_dout <= lat_a;
  end
  always @(posedge clk) begin
    if (b_rrst) b_dout <= '0;
    else if (b_en) begin
      if (b_we) mem_b[b_addr] <= b_din;
      b_dout <= mem_b[b_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle behaviour, filled when the bench decides a read is accepted
  bit            sa_v [N], sa_id [N], sa_busy [N], sa_ce [N];
  bit            sb_v [N], sb_id [N], sb_busy [N];
  logic [DW-1:0] sa_d [N], sb_d [N];
  logic [DW-1:0] exp_mem [1024];

  task automatic clear_sched(input int from);
    for (int i = from; i < N; i++) begin
      sa_v[i] = 0; sa_id[i] = 0; sa_busy[i] = 0; sa_ce[i] = 0; sa_d[i] = '0;
      sb_v[i] = 0; sb_id[i] = 0; sb_busy[i] = 0; sb_d[i] = '0;
    end
  endtask

  task automatic sched_read(input int c, input bit id, input logic [DW-1:0] d);
    sa_v[c+3] = 1; sa_id[c+3] = id; sa_d[c+3] = d; sa_ce[c+2] = 1;
    for (int k = 1; k <= 3; k++) sa_busy[c+k] = 1;
    sb_v[c+2] = 1; sb_id[c+2] = id; sb_d[c+2] = d;
    for (int k = 1; k <= 2; k++) sb_busy[c+k] = 1;
  endtask

  bit mon_en = 0;
  always @(negedge clk) begin
    if (mon_en && cyc < N) begin
      check("a rsp0_valid", a_rsp0_valid, sa_v[cyc] && !sa_id[cyc]);
      check("a rsp1_valid", a_rsp1_valid, sa_v[cyc] && sa_id[cyc]);
      if (sa_v[cyc]) check("a rdata", sa_id[cyc] ? a_rsp1_rdata : a_rsp0_rdata, sa_d[cyc]);
      check("a busy", a_busy, sa_busy[cyc]);
      check("a regce", a_regce, sa_ce[cyc]);
      check("b rsp0_valid", b_rsp0_valid, sb_v[cyc] && !sb_id[cyc]);
      check("b rsp1_valid", b_rsp1_valid, sb_v[cyc] && sb_id[cyc]);
      if (sb_v[cyc]) check("b rdata", sb_id[cyc] ? b_rsp1_rdata : b_rsp0_rdata, sb_d[cyc]);
      check("b busy", b_busy, sb_busy[cyc]);
      check("b regce", b_regce, 1'b1);
    end
  end

  // One cycle: present requests, check grants, then check the registered command
  task automatic drive(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input bit g0, input bit g1, input string tag);
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    #1;
    check({tag, " ready0"}, a_ready0, g0);
    check({tag, " ready1"}, a_ready1, g1);
    check({tag, " ll ready0"}, b_ready0, g0);
    check({tag, " ll ready1"}, b_ready1, g1);
    w = g1 ? w1 : w0;
    a = g1 ? a1 : a0;
    d = g1 ? d1 : d0;
    if (g0 || g1) begin
      if (w) exp_mem[a] = d;
      else sched_read(cyc, g1, exp_mem[a]);
    end
    @(posedge clk); #1;
    check({tag, " ram_en"}, a_en, g0 || g1);
    check({tag, " ram_we"}, a_we, (g0 || g1) && w);
    if (g0 || g1) begin
      check({tag, " ram_addr"}, a_addr, a);
      check({tag, " ram_din"}, a_din, d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    clear_sched(0);
    #1 rst = 1'b1;
    req0_valid = 1'b1;
    #2;
    check("reset ready0", a_ready0, 1'b0);
    check("reset ram_en", a_en, 1'b0);
    check("reset ram_addr", a_addr, 0);
    check("reset busy", a_busy, 1'b0);
    check("reset ram_rst", a_rrst, 1'b1);
    req0_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;

    // 1 / 6: write 5 = 0x155 then read back
    drive(1, 1, 5, 18'h155, 0, 0, 0, 0, 1, 0, "t1 wr");
    drive(1, 0, 5, 18'h000, 0, 0, 0, 0, 1, 0, "t1 rd");
    idle(5);

    // preload 0..3, last from req1 so the tie goes to req0 next
    drive(1, 1, 0, 18'h100, 0, 0, 0, 0, 1, 0, "pre0");
    drive(1, 1, 1, 18'h111, 0, 0, 0, 0, 1, 0, "pre1");
    drive(1, 1, 2, 18'h122, 0, 0, 0, 0, 1, 0, "pre2");
    drive(0, 0, 0, 0, 1, 1, 3, 18'h133, 0, 1, "pre3");

    // 2: both valid, strict alternation
    drive(1, 0, 0, 0, 1, 0, 1, 0, 1, 0, "t2 c0");
    drive(1, 0, 2, 0, 1, 0, 1, 0, 0, 1, "t2 c1");
    drive(1, 0, 2, 0, 1, 0, 3, 0, 1, 0, "t2 c2");
    drive(1, 0, 0, 0, 1, 0, 3, 0, 0, 1, "t2 c3");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "t2 c4");
    idle(5);

    // 3: req1 streaming reads
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] ad;
      ad = AW'(i % 4);
      drive(0, 0, 0, 0, 1, 0, ad, 0, 0, 1, "t3");
    end
    idle(5);

    // 4: write by req0 visible to req1 read next cycle
    drive(1, 1, 7, 18'h02A, 0, 0, 0, 0, 1, 0, "t4 wr");
    drive(0, 0, 0, 0, 1, 0, 7, 0, 0, 1, "t4 rd");
    idle(5);

    // 5: reset with two reads in flight
    drive(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "t5 rd0");
    drive(0, 0, 0, 0, 1, 0, 2, 0, 0, 1, "t5 rd1");
    clear_sched(cyc);
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t5 busy", a_busy, 1'b0);
    check("t5 ll busy", b_busy, 1'b0);
    check("t5 rsp0", a_rsp0_valid, 1'b0);
    check("t5 rsp1", a_rsp1_valid, 1'b0);
    check("t5 ram_en", a_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
